// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation encodings and the control bundle
// that travels with each instruction from decode into EX.
package cpu_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_ORI  = 4'b1101;

  typedef enum logic [1:0] {
    ALU_RTYPE = 2'b00,
    ALU_ADD   = 2'b01,
    ALU_SUB   = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_w;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_w;
  } ctrl_t;

  // Reference decode of the supported opcodes; anything unknown decodes to a no-op.
  function automatic ctrl_t decode_ctrl(input logic [3:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_R:    begin c.alu_op = ALU_RTYPE; c.reg_dst = 1'b1; c.reg_w = 1'b1; end
      OP_LW:   begin c.alu_op = ALU_ADD; c.reg_w = 1'b1; c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
      OP_SW:   begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_w = 1'b1; end
      OP_ADDI: begin c.alu_op = ALU_ADD; c.reg_w = 1'b1; c.alu_src = 1'b1; end
      OP_ORI:  begin c.alu_op = ALU_OR; c.reg_w = 1'b1; c.alu_src = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection: flags when the op in ID needs a register that the load
// currently in EX has not yet produced.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int RA_W = 2
) (
  input  logic            id_valid,
  input  logic            id_alu_src,
  input  logic            id_mem_w,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_valid,
  input  logic            ex_mem_to_reg,
  input  logic            ex_reg_w,
  input  logic [RA_W-1:0] ex_wr_addr,
  output logic            reads_rt,
  output logic            hazard
);

  // Stores read rt as their data source even though operand B is the immediate.
  assign reads_rt = ~id_alu_src | id_mem_w;

  assign hazard = id_valid & ex_valid & ex_mem_to_reg & ex_reg_w &
                  ((ex_wr_addr == id_rs) | (reads_rt & (ex_wr_addr == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, hold and a saturating count of
// inserted bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_dst,
  input  logic              id_reg_w,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_w,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_reg_dst,
  output logic              ex_reg_w,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_w,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   ex_wr_addr,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  reads_rt_unused;

  hazard_unit #(.RA_W(RA_W)) u_hazard (
    .id_valid      (id_valid),
    .id_alu_src    (id_alu_src),
    .id_mem_w      (id_mem_w),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_valid      (ex_valid),
    .ex_mem_to_reg (ex_ctrl.mem_to_reg),
    .ex_reg_w      (ex_ctrl.reg_w),
    .ex_wr_addr    (ex_wr_addr),
    .reads_rt      (reads_rt_unused),
    .hazard        (hazard)
  );

  assign pc_write    = ~(hazard | hold);
  assign if_id_write = ~(hazard | hold);

  // An empty IF/ID slot must never write architectural state once it reaches EX.
  always_comb begin
    id_ctrl            = '0;
    id_ctrl.alu_op     = id_alu_op;
    id_ctrl.reg_dst    = id_reg_dst;
    id_ctrl.reg_w      = id_reg_w & id_valid;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.mem_w      = id_mem_w & id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || (!hold && hazard)) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_wr_addr <= '0;
    end else if (!hold) begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_ctrl;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_wr_addr <= id_reg_dst ? id_rd : id_rt;
    end
  end

  // Only bubbles actually inserted by the hazard path are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!flush && !hold && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_reg_w      = ex_ctrl.reg_w;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_w      = ex_ctrl.mem_w;

endmodule
